// File: rtl/sleep_request_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sleep_request_master_pkg
// Description : Shared event-unit sleep register map, bit indices, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package sleep_request_master_pkg;

    localparam int unsigned SLEEP_CTRL_OFFSET   = 32'h0;
    localparam int unsigned SLEEP_STATUS_OFFSET = 32'h4;
    localparam int unsigned SLEEP_CTRL_EN_BIT   = 0;
    localparam int unsigned SLEEP_STATUS_BIT    = 0;

    localparam int unsigned SLEEP_CNT_W = 8;

    typedef logic [2:0] sleep_state_t;

    localparam sleep_state_t ST_IDLE      = 3'd0;
    localparam sleep_state_t ST_WR_SETUP  = 3'd1;
    localparam sleep_state_t ST_WR_ACCESS = 3'd2;
    localparam sleep_state_t ST_GAP       = 3'd3;
    localparam sleep_state_t ST_RD_SETUP  = 3'd4;
    localparam sleep_state_t ST_RD_ACCESS = 3'd5;
    localparam sleep_state_t ST_HOLD      = 3'd6;

endpackage
`default_nettype wire

// File: rtl/sleep_request_master.sv
`default_nettype none
// ============================================================================
// Module      : sleep_request_master
// Description : APB requester that enables core sleep and polls for status.
// Revision    : 1.0 - initial release
// ============================================================================
module sleep_request_master
    import sleep_request_master_pkg::*;
#(
    parameter int                        APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        POLL_GAP       = 4,
    parameter int                        MAX_POLLS      = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      sleep_req_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam logic [SLEEP_CNT_W-1:0]    c_poll_gap    = SLEEP_CNT_W'(POLL_GAP);
    localparam logic [SLEEP_CNT_W-1:0]    c_max_polls   = SLEEP_CNT_W'(MAX_POLLS);
    localparam logic [APB_ADDR_WIDTH-1:0] c_ctrl_addr   = BASE_ADDR + APB_ADDR_WIDTH'(SLEEP_CTRL_OFFSET);
    localparam logic [APB_ADDR_WIDTH-1:0] c_status_addr = BASE_ADDR + APB_ADDR_WIDTH'(SLEEP_STATUS_OFFSET);
    localparam logic [31:0]               c_ctrl_wdata  = 32'h1 << SLEEP_CTRL_EN_BIT;

    sleep_state_t             r_state;
    sleep_state_t             w_state_nxt;
    logic [SLEEP_CNT_W-1:0]   r_gap_cnt;
    logic [SLEEP_CNT_W-1:0]   w_gap_nxt;
    logic [SLEEP_CNT_W-1:0]   r_poll_cnt;
    logic [SLEEP_CNT_W-1:0]   w_poll_nxt;
    logic [SLEEP_CNT_W-1:0]   w_poll_inc;
    logic                     r_done;
    logic                     r_err;
    logic                     w_done_nxt;
    logic                     w_err_nxt;
    logic                     w_wr_phase;
    logic                     w_rd_phase;
    logic                     w_unused_prdata;

    // Only the status bit matters; the remaining read data is ignored.
    assign w_unused_prdata = ^PRDATA;

    assign w_poll_inc = (r_poll_cnt == {SLEEP_CNT_W{1'b1}}) ? r_poll_cnt : r_poll_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_poll_nxt  = r_poll_cnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sleep_req_i) begin
                    w_state_nxt = ST_WR_SETUP;
                    w_poll_nxt  = '0;
                end
            end
            ST_WR_SETUP: w_state_nxt = ST_WR_ACCESS;
            ST_WR_ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_gap_nxt   = c_poll_gap;
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt != '0) begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end
                if (r_gap_cnt <= 1) begin
                    w_state_nxt = ST_RD_SETUP;
                end
            end
            ST_RD_SETUP: w_state_nxt = ST_RD_ACCESS;
            ST_RD_ACCESS: begin
                if (PREADY) begin
                    w_poll_nxt = w_poll_inc;
                    // Bus error outranks status, status outranks timeout.
                    if (PSLVERR) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else if (PRDATA[SLEEP_STATUS_BIT]) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else if (w_poll_inc == c_max_polls) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_gap_nxt   = c_poll_gap;
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_HOLD: begin
                if (!sleep_req_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_gap_cnt  <= '0;
            r_poll_cnt <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_poll_cnt <= w_poll_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign w_wr_phase = (r_state == ST_WR_SETUP) || (r_state == ST_WR_ACCESS);
    assign w_rd_phase = (r_state == ST_RD_SETUP) || (r_state == ST_RD_ACCESS);

    // APB signals decode from state so reset clears them without a clock.
    assign PSEL    = w_wr_phase || w_rd_phase;
    assign PENABLE = (r_state == ST_WR_ACCESS) || (r_state == ST_RD_ACCESS);
    assign PWRITE  = w_wr_phase;
    assign PADDR   = w_wr_phase ? c_ctrl_addr : (w_rd_phase ? c_status_addr : '0);
    assign PWDATA  = w_wr_phase ? c_ctrl_wdata : 32'h0;

    assign busy_o  = (r_state != ST_IDLE) && (r_state != ST_HOLD);
    assign done_o  = r_done;
    assign err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sleep_request_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_sleep_request_master
// Description : Directed bench with a configurable APB completer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sleep_request_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        sleep_req_i;
    logic        busy_o, done_o, err_o;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA  = 32'h0;
    logic        PREADY  = 1'b0;
    logic        PSLVERR = 1'b0;

    always #5 HCLK = ~HCLK;

    sleep_request_master #(
        .APB_ADDR_WIDTH (12),
        .BASE_ADDR      (12'h100),
        .POLL_GAP       (4),
        .MAX_POLLS      (3)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .sleep_req_i (sleep_req_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    int total = 0;
    int bad   = 0;

    int          wait_n = 0;
    bit          err_wr = 1'b0;
    bit          st [0:7];
    int          ridx = 0;
    int          cyc = 0, wr_cnt = 0, rd_cnt = 0, n_done = 0, n_err = 0, viol = 0;
    int          last_cmpl = 0, done_cyc = 0, acc = 0;
    logic [11:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [11:0] rd_addr [0:7];
    int          gaps    [0:7];
    logic [11:0] s_addr = '0;
    logic [31:0] s_data = '0;
    logic        s_wr = 1'b0;
    bit          s_bit;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Completer and protocol monitor; runs on the falling edge.
    always @(negedge HCLK) begin
        cyc++;
        if (PENABLE && !PSEL) viol++;
        if (!(PSEL && PWRITE) && PWDATA != 32'h0) viol++;
        if (done_o && err_o) viol++;
        if (done_o) begin n_done++; done_cyc = cyc; end
        if (err_o) n_err++;
        if (PSEL && !PENABLE) begin
            s_addr = PADDR; s_data = PWDATA; s_wr = PWRITE; acc = 0;
            if (!PWRITE && rd_cnt < 8) gaps[rd_cnt] = cyc - last_cmpl - 1;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'hFFFF_FFFF;
        if (PSEL && PENABLE) begin
            if (PADDR != s_addr || PWDATA != s_data || PWRITE != s_wr) viol++;
            if (acc >= wait_n) begin
                PREADY    = 1'b1;
                last_cmpl = cyc;
                if (PWRITE) begin
                    PSLVERR = err_wr;
                    wr_addr = PADDR; wr_data = PWDATA; wr_cnt++;
                end else begin
                    s_bit  = (ridx < 8) ? st[ridx] : 1'b0;
                    ridx++;
                    PRDATA = 32'hFFFF_FFFE | {31'h0, s_bit};
                    if (rd_cnt < 8) rd_addr[rd_cnt] = PADDR;
                    rd_cnt++;
                end
            end
            acc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic clear_log();
        wr_cnt = 0; rd_cnt = 0; n_done = 0; n_err = 0; viol = 0; ridx = 0;
        for (int i = 0; i < 8; i++) begin gaps[i] = -1; rd_addr[i] = '0; end
    endtask

    task automatic set_status(input bit [7:0] v);
        for (int i = 0; i < 8; i++) st[i] = v[i];
    endtask

    task automatic wait_result(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge HCLK); #1;
            if (done_o || err_o) break;
        end
        chk(tag, {31'h0, done_o | err_o}, 32'h1);
    endtask

    task automatic check_done_run(input string tag);
        chk({tag, "_wr_cnt"}, wr_cnt, 1);
        chk({tag, "_wr_addr"}, {20'h0, wr_addr}, 32'h100);
        chk({tag, "_wr_data"}, wr_data, 32'h1);
        chk({tag, "_rd_cnt"}, rd_cnt, 3);
        chk({tag, "_rd_addr"}, {20'h0, rd_addr[0] | rd_addr[1] | rd_addr[2]}, 32'h104);
        chk({tag, "_gap0"}, gaps[0], 4);
        chk({tag, "_gap1"}, gaps[1], 4);
        chk({tag, "_gap2"}, gaps[2], 4);
        chk({tag, "_done_cnt"}, n_done, 1);
        chk({tag, "_err_cnt"}, n_err, 0);
        chk({tag, "_done_lat"}, done_cyc - last_cmpl, 1);
        chk({tag, "_viol"}, viol, 0);
    endtask

    initial begin
        HRESETn     = 1'b0;
        sleep_req_i = 1'b0;
        set_status(8'h00);
        clear_log();
        #3;
        chk("rst_ctrl", {26'h0, PSEL, PENABLE, PWRITE, busy_o, done_o, err_o}, 32'h0);
        chk("rst_addr", {20'h0, PADDR}, 32'h0);
        chk("rst_wdata", PWDATA, 32'h0);
        tick(3);
        HRESETn = 1'b1;
        tick(2);

        // Zero-wait completer, status 0,0,1 -> done on third read.
        wait_n = 0; err_wr = 1'b0; clear_log(); set_status(8'b0000_0100);
        sleep_req_i = 1'b1;
        wait_result("a_result", 200);
        tick(10);
        check_done_run("a");
        chk("a_hold_busy", {31'h0, busy_o}, 32'h0);

        // Request held high after done: no new activity; re-raise restarts.
        clear_log();
        tick(20);
        chk("e_no_restart", wr_cnt + rd_cnt, 0);
        sleep_req_i = 1'b0;
        tick(2);
        clear_log(); set_status(8'b0000_0001);
        sleep_req_i = 1'b1;
        wait_result("e_result", 200);
        chk("e_new_write", wr_cnt, 1);
        chk("e_new_done", {31'h0, done_o}, 32'h1);
        sleep_req_i = 1'b0;
        tick(4);

        // Three wait states per access; same outcome, stable address/data.
        wait_n = 3; clear_log(); set_status(8'b0000_0100);
        sleep_req_i = 1'b1;
        wait_result("b_result", 300);
        tick(10);
        check_done_run("b");
        sleep_req_i = 1'b0;
        tick(4);

        // Error on the write: err pulse, no reads, held until request drops.
        wait_n = 0; err_wr = 1'b1; clear_log(); set_status(8'h00);
        sleep_req_i = 1'b1;
        wait_result("c_result", 100);
        chk("c_err_now", {30'h0, err_o, done_o}, 32'h2);
        tick(15);
        chk("c_err_cnt", n_err, 1);
        chk("c_rd_cnt", rd_cnt, 0);
        chk("c_wr_cnt", wr_cnt, 1);
        chk("c_hold_idle_bus", {30'h0, busy_o, PSEL}, 32'h0);
        sleep_req_i = 1'b0;
        tick(2);
        sleep_req_i = 1'b1;
        tick(4);
        chk("c_restart", wr_cnt, 2);
        sleep_req_i = 1'b0;
        tick(6);

        // Status never set: timeout after exactly MAX_POLLS reads, even with request dropped.
        err_wr = 1'b0; clear_log(); set_status(8'h00);
        sleep_req_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (rd_cnt > 0) break;
        end
        chk("d_first_read", {31'h0, rd_cnt > 0}, 32'h1);
        sleep_req_i = 1'b0;
        wait_result("d_result", 200);
        tick(10);
        chk("d_rd_cnt", rd_cnt, 3);
        chk("d_err_cnt", n_err, 1);
        chk("d_done_cnt", n_done, 0);
        chk("d_idle_after", {31'h0, busy_o}, 32'h0);

        // Reset during a read access: immediate clear, no pulse afterwards.
        wait_n = 3; clear_log(); set_status(8'h01);
        sleep_req_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (PSEL && PENABLE && !PWRITE) break;
        end
        chk("f_in_rd_access", {29'h0, PSEL, PENABLE, PWRITE}, 32'h6);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("f_rst_ctrl", {26'h0, PSEL, PENABLE, PWRITE, busy_o, done_o, err_o}, 32'h0);
        chk("f_rst_addr", {20'h0, PADDR}, 32'h0);
        chk("f_rst_wdata", PWDATA, 32'h0);
        sleep_req_i = 1'b0;
        tick(3);
        clear_log();
        HRESETn = 1'b1;
        tick(20);
        chk("f_no_pulse", n_done + n_err, 0);
        chk("f_no_activity", wr_cnt + rd_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
